branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor. It pairs a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Each cycle it predicts taken/not-taken and the target for the fetch PC. It is trained by the execute-stage branch resolution results (taken flag, actual target, misprediction flag), closing the loop with the EX-stage branch resolver.

## Interface
- INDEX_BITS, 4: log2 of entry count (16 entries). Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- IF_pc  input  32  current fetch PC (lookup address).
- branch_estimation  output  1  predicted taken for IF_pc (combinational).
- branch_target_estimated  output  32  predicted target; IF_pc + 4 when branch_estimation = 0.
- update_valid  input  1  EX stage holds a resolved conditional branch this cycle.
- update_pc  input  32  PC of the resolved branch.
- update_taken  input  1  actual outcome.
- update_target  input  32  actual taken target (pc + imm).
- update_miss  input  1  resolver flagged a misprediction; valid only with update_valid.
- miss_count  output  16  saturating count of mispredictions since reset.

## Operation
- Per entry: valid (1), tag (32-INDEX_BITS-2), target (32), ctr (2).
- Lookup: hit = valid[i] && tag[i] == IF_pc tag field. branch_estimation = hit && ctr[i][1]. branch_target_estimated = branch_estimation ? target[i] : IF_pc + 4 (32-bit wrap).
- Update (rising edge, update_valid = 1), with uhit = valid and tag match for update_pc:
  - uhit, taken: ctr = min(ctr+1, 3); target = update_target.
  - uhit, not taken: ctr = max(ctr-1, 0); target unchanged; entry stays valid.
  - !uhit, taken: allocate/replace. valid = 1, tag, target = update_target, ctr = 2'b10 (weakly taken).
  - !uhit, not taken: no change.
- miss_count increments when update_valid && update_miss, and saturates at 16'hFFFF.
- update_valid = 0: no state change; update_* values are don't-care.
- pc[1:0] is ignored for both index and tag.

## Timing
- Reset (async assert, any cycle): all valid = 0, all ctr = 2'b01, all targets = 0, miss_count = 0. With no hits, branch_estimation = 0 and branch_target_estimated = IF_pc + 4 while reset is held and after release.
- Lookup latency: 0 cycles (combinational from IF_pc and stored state).
- Update latency: 1 cycle. State written at edge N is visible to lookups after edge N.
- Same-cycle lookup and update to the same entry: the lookup returns pre-update state (read-old). No bypass.
- One update per cycle. No stall or handshake. The caller holds update_valid for exactly one cycle per resolved branch.
- Reset asserted mid-training: state clears immediately and the next edge is ignored while reset = 0.

## Test plan
- Reset: pulse reset low mid-run with IF_pc = 0x100 -> branch_estimation = 0, target = 0x104, miss_count = 0 immediately.
- Allocation: update pc 0x40, taken, target 0x80 -> next cycle IF_pc = 0x40 gives estimation 1, target 0x80. IF_pc = 0x44 gives 0 / 0x48.
- Saturation and hysteresis: from ctr = 2, two taken updates reach ctr = 3. Then one not-taken update -> still predicts taken (ctr 2). A second not-taken -> predicts not taken (ctr 1). Two more not-taken -> ctr 0, entry still valid.
- Aliasing: allocate pc 0x40 (idx 0). Then update pc 0x440, taken, target 0x500 -> 0x440 predicts 0x500, and 0x40 now misses (tag mismatch) -> 0 / 0x44.
- Read-old: IF_pc = update_pc = 0x20 in the same cycle as an allocating update -> estimation 0 that cycle, 1 the following cycle.
- Miss counter: 3 cycles of update_valid = 1, update_miss = 1 -> miss_count = 3. update_miss = 1 with update_valid = 0 -> no increment. Preload to 0xFFFF and add a miss -> stays 0xFFFF.

Source files
------------

// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor
// ----------------------------------------------------------------------------
// Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer
// whose entries each carry a 2-bit saturating direction counter. Lookups are
// purely combinational on IF_pc; training arrives from the execute-stage
// branch resolver and is written on the rising clock edge.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-low; clears all state
//   IF_pc                    fetch PC to look up
//   branch_estimation        predicted taken for IF_pc (combinational)
//   branch_target_estimated  predicted target, IF_pc + 4 when not taken
//   update_valid             a resolved conditional branch is present
//   update_pc                PC of the resolved branch
//   update_taken             actual branch outcome
//   update_target            actual taken target
//   update_miss              resolver flagged a misprediction
//   miss_count               saturating misprediction count since reset
//
// Update port protocol: update_valid is a single-cycle, fire-and-forget
// strobe. There is no ready/backpressure; every cycle with update_valid high
// at a rising edge is consumed exactly once, and update_* are ignored when
// update_valid is low.
// ============================================================================
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_pc,
    output logic        branch_estimation,
    output logic [31:0] branch_target_estimated,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_miss,
    output logic [15:0] miss_count
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [15:0]         miss_count_q;

    // Byte-offset bits never participate in index or tag.
    logic unused_pc_low;
    assign unused_pc_low = ^{IF_pc[1:0], update_pc[1:0]};

    // ------------------------------------------------------------------------
    // Lookup path (combinational, reads current stored state only, so a
    // same-cycle update to the same entry is not visible until after the edge)
    // ------------------------------------------------------------------------
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;

    always_comb begin
        lk_idx = IF_pc[INDEX_BITS+1:2];
        lk_tag = IF_pc[31:INDEX_BITS+2];
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

        branch_estimation       = lk_hit && ctr_q[lk_idx][1];
        branch_target_estimated = branch_estimation ? target_q[lk_idx]
                                                    : 32'(IF_pc + 32'd4);
    end

    // ------------------------------------------------------------------------
    // Update path: decide whether the indexed entry is written and with what
    // ------------------------------------------------------------------------
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic                  up_write;
    logic [1:0]            up_ctr_next;

    always_comb begin
        up_idx      = update_pc[INDEX_BITS+1:2];
        up_tag      = update_pc[31:INDEX_BITS+2];
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr_next = ctr_q[up_idx];

        if (up_hit) begin
            if (update_taken) begin
                up_ctr_next = (ctr_q[up_idx] == 2'b11) ? 2'b11
                                                       : 2'(ctr_q[up_idx] + 2'd1);
            end else begin
                up_ctr_next = (ctr_q[up_idx] == 2'b00) ? 2'b00
                                                       : 2'(ctr_q[up_idx] - 2'd1);
            end
        end else begin
            // Allocation starts weakly taken so the very next visit predicts
            // taken, but a single not-taken outcome flips it.
            up_ctr_next = 2'b10;
        end

        // A not-taken branch that misses the BTB is not worth an entry.
        up_write = update_valid && (up_hit || update_taken);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (up_write) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            ctr_q[up_idx]   <= up_ctr_next;
            // Not-taken hits keep the last known taken target.
            if (update_taken) begin
                target_q[up_idx] <= update_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_count_q <= '0;
        end else if (update_valid && update_miss && (miss_count_q != 16'hFFFF)) begin
            miss_count_q <= miss_count_q + 16'd1;
        end
    end

    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ============================================================================
// tb_branch_predictor
// ----------------------------------------------------------------------------
// Directed testbench for branch_predictor. Inputs change 1 ns after a rising
// edge; combinational outputs are sampled a further 1 ns later, well away
// from the active edge. Expected values are hand-derived from the predictor's
// behaviour (allocation at weakly taken, saturating 2-bit counters,
// read-old lookup, saturating miss counter).
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] IF_pc;
    logic        branch_estimation;
    logic [31:0] branch_target_estimated;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_miss;
    logic [15:0] miss_count;

    int n_checks;
    int n_errors;

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .IF_pc                   (IF_pc),
        .branch_estimation       (branch_estimation),
        .branch_target_estimated (branch_target_estimated),
        .update_valid            (update_valid),
        .update_pc               (update_pc),
        .update_taken            (update_taken),
        .update_target           (update_target),
        .update_miss             (update_miss),
        .miss_count              (miss_count)
    );

    // ------------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Look up a PC and compare both prediction outputs.
    task automatic check_lookup(input string tag, input logic [31:0] pc,
                                input logic est, input logic [31:0] tgt);
        IF_pc = pc;
        #1;
        check({tag, ".est"}, {31'd0, branch_estimation}, {31'd0, est});
        check({tag, ".tgt"}, branch_target_estimated, tgt);
    endtask

    // ------------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------------
    task automatic idle_inputs();
        update_valid  = 1'b0;
        update_pc     = 32'h0;
        update_taken  = 1'b0;
        update_target = 32'h0;
        update_miss   = 1'b0;
    endtask

    // One resolved branch, consumed at the next rising edge.
    task automatic drive_update(input logic [31:0] pc, input logic taken,
                                input logic [31:0] tgt, input logic miss);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_taken  = taken;
        update_target = tgt;
        update_miss   = miss;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        IF_pc = 32'h100;
        reset = 1'b0;
        #2;
        check_lookup("por", 32'h100, 1'b0, 32'h104);
        check("por.miss", {16'd0, miss_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Allocation
        drive_update(32'h40, 1'b1, 32'h80, 1'b0);
        check_lookup("alloc.hit", 32'h40, 1'b1, 32'h80);
        check_lookup("alloc.nbr", 32'h44, 1'b0, 32'h48);

        // Saturation and hysteresis (ctr starts at 2)
        drive_update(32'h40, 1'b1, 32'h80, 1'b0);   // 3
        drive_update(32'h40, 1'b1, 32'h80, 1'b0);   // stays 3
        drive_update(32'h40, 1'b0, 32'h0,  1'b0);   // 2
        check_lookup("hyst.ctr2", 32'h40, 1'b1, 32'h80);
        drive_update(32'h40, 1'b0, 32'h0,  1'b0);   // 1
        check_lookup("hyst.ctr1", 32'h40, 1'b0, 32'h44);
        drive_update(32'h40, 1'b0, 32'h0,  1'b0);   // 0
        drive_update(32'h40, 1'b0, 32'h0,  1'b0);   // stays 0
        check_lookup("hyst.ctr0", 32'h40, 1'b0, 32'h44);
        // Still valid: taken hit goes 0->1 (no reallocation at weakly taken).
        drive_update(32'h40, 1'b1, 32'h90, 1'b0);
        check_lookup("hyst.valid", 32'h40, 1'b0, 32'h44);
        drive_update(32'h40, 1'b1, 32'h90, 1'b0);   // 2, target now 0x90
        check_lookup("hyst.retrain", 32'h40, 1'b1, 32'h90);

        // Aliasing on index 0
        drive_update(32'h440, 1'b1, 32'h500, 1'b0);
        check_lookup("alias.new", 32'h440, 1'b1, 32'h500);
        check_lookup("alias.old", 32'h40, 1'b0, 32'h44);
        check_lookup("alias.lowbits", 32'h443, 1'b1, 32'h500);

        // Read-old: lookup and allocating update to the same entry together
        IF_pc         = 32'h20;
        update_valid  = 1'b1;
        update_pc     = 32'h20;
        update_taken  = 1'b1;
        update_target = 32'h60;
        update_miss   = 1'b0;
        #1;
        check("readold.before", {31'd0, branch_estimation}, 32'd0);
        check("readold.before_tgt", branch_target_estimated, 32'h24);
        @(posedge clk);
        #1;
        idle_inputs();
        check_lookup("readold.after", 32'h20, 1'b1, 32'h60);

        // Mid-run reset, with an update held across an edge during reset
        IF_pc         = 32'h100;
        update_valid  = 1'b1;
        update_pc     = 32'h440;
        update_taken  = 1'b1;
        update_target = 32'h700;
        update_miss   = 1'b1;
        reset = 1'b0;
        #1;
        check_lookup("rst.idle", 32'h100, 1'b0, 32'h104);
        check_lookup("rst.cleared", 32'h440, 1'b0, 32'h444);
        check("rst.miss", {16'd0, miss_count}, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b1;
        check_lookup("rst.ignored_edge", 32'h440, 1'b0, 32'h444);
        check("rst.ignored_miss", {16'd0, miss_count}, 32'd0);

        // Miss counter
        repeat (3) drive_update(32'h0, 1'b0, 32'h0, 1'b1);
        check("miss.three", {16'd0, miss_count}, 32'd3);
        update_miss = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        check("miss.novalid", {16'd0, miss_count}, 32'd3);
        for (int i = 3; i < 32'hFFFE; i++) begin
            drive_update(32'h0, 1'b0, 32'h0, 1'b1);
        end
        check("miss.fffe", {16'd0, miss_count}, 32'h0000FFFE);
        drive_update(32'h0, 1'b0, 32'h0, 1'b1);
        check("miss.ffff", {16'd0, miss_count}, 32'h0000FFFF);
        drive_update(32'h0, 1'b0, 32'h0, 1'b1);
        check("miss.sat", {16'd0, miss_count}, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
